simple_trace_capture: RTL and testbench

//   Synthesizable run controller and trace recorder for the SIMPLE core. Sequences the

---
 rtl/simple_trace_capture.sv | 140 ++++++++++++++
 tb/tb_simple_trace_capture.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/simple_trace_capture.sv
// Run controller and circular trace recorder for the SIMPLE core: sequences the core
// reset, bounds the run length, and records one {pc, addr, instr, szcv, jflag} per capture phase.
module simple_trace_capture #(
  parameter int unsigned        PC_W      = 16,
  parameter int unsigned        INSTR_W   = 16,
  parameter int unsigned        PHASE_W   = 5,
  parameter logic [PHASE_W-1:0] CAP_PHASE = 5'b10000,
  parameter int unsigned        DEPTH     = 32,
  parameter int unsigned        RST_CYC   = 4,
  parameter int unsigned        CYC_W     = 16,
  localparam int unsigned       AW        = $clog2(DEPTH),
  localparam int unsigned       REC_W     = 2*PC_W + INSTR_W + 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               restart,
  input  logic [CYC_W-1:0]   max_cycles,
  input  logic               trig_en,
  input  logic [PC_W-1:0]    trig_pc,
  input  logic [AW:0]        post_cnt,
  input  logic [PHASE_W-1:0] phase_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [PC_W-1:0]    addr_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [3:0]         szcv_i,
  input  logic               jflag_i,
  output logic               core_rst,
  output logic               running,
  output logic               triggered,
  output logic               done,
  output logic [AW:0]        count,
  output logic [CYC_W-1:0]   cycles,
  input  logic [AW-1:0]      rd_idx,
  output logic [REC_W-1:0]   rd_data
);

  localparam int unsigned  HW         = $clog2(RST_CYC + 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(RST_CYC - 1);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);

  typedef enum logic [1:0] {ST_HOLD, ST_RUN, ST_POST, ST_DONE} state_t;

  state_t           state, state_next;
  logic [HW-1:0]    hold_cnt;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      remaining;
  logic [REC_W-1:0] mem [DEPTH];
  logic             active, capture, trig_hit, limit_hit, post_last;
  logic [AW-1:0]    rd_slot;
  logic             rd_valid;

  assign active    = (state == ST_RUN) || (state == ST_POST);
  assign capture   = active && !restart && (phase_i == CAP_PHASE);
  assign trig_hit  = (state == ST_RUN) && capture && trig_en && (pc_i == trig_pc);
  assign limit_hit = active && (max_cycles != '0) && ((cycles + CYC_W'(1)) == max_cycles);
  assign post_last = (state == ST_POST) && capture && (remaining == CNT_ONE);

  // Oldest valid entry sits count slots behind the write pointer; a full buffer wraps to wr_ptr.
  assign rd_slot  = wr_ptr - count[AW-1:0] + rd_idx;
  assign rd_valid = ({1'b0, rd_idx} < count);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_HOLD;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (restart) begin
      state_next = ST_HOLD;
    end else begin
      case (state)
        ST_HOLD: if (hold_cnt == HOLD_LAST) state_next = ST_RUN;
        ST_RUN: begin
          if (limit_hit || (trig_hit && post_cnt == '0)) state_next = ST_DONE;
          else if (trig_hit)                             state_next = ST_POST;
        end
        ST_POST: if (limit_hit || post_last) state_next = ST_DONE;
        default: state_next = state;
      endcase
    end
  end

  always_comb begin
    core_rst = 1'b1;
    running  = 1'b0;
    done     = 1'b0;
    case (state)
      ST_RUN, ST_POST: begin
        core_rst = 1'b0;
        running  = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: core_rst = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt  <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      cycles    <= '0;
      remaining <= '0;
      triggered <= 1'b0;
    end else if (restart) begin
      hold_cnt  <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      cycles    <= '0;
      triggered <= 1'b0;
    end else begin
      if (state == ST_HOLD) hold_cnt <= hold_cnt + HW'(1);
      if (active && cycles != '1) cycles <= cycles + CYC_W'(1);
      if (capture) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (count != FULL_COUNT) count <= count + CNT_ONE;
      end
      if (trig_hit) begin
        triggered <= 1'b1;
        remaining <= post_cnt;
      end else if (state == ST_POST && capture) begin
        remaining <= remaining - CNT_ONE;
      end
    end
  end

  // Trace RAM is deliberately left unreset so contents survive a restart.
  always_ff @(posedge clk) begin
    if (capture) mem[wr_ptr] <= {pc_i, addr_i, instr_i, szcv_i, jflag_i};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          rd_data <= '0;
    else if (rd_valid) rd_data <= mem[rd_slot];
    else               rd_data <= '0;
  end

endmodule

// File: tb/tb_simple_trace_capture.sv
// Directed bench for simple_trace_capture: reset sequencing, cycle limit, wrap,
// trigger/post-count, restart and the trigger-plus-limit corner.
module tb_simple_trace_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        restart = 1'b0;
  logic [15:0] max_cycles = '0;
  logic        trig_en = 1'b0;
  logic [15:0] trig_pc = '0;
  logic [5:0]  post_cnt = '0;
  logic [4:0]  phase_i = '0;
  logic [15:0] pc_i = '0;
  logic [15:0] addr_i = '0;
  logic [15:0] instr_i = '0;
  logic [3:0]  szcv_i = '0;
  logic        jflag_i = 1'b0;
  logic        core_rst, running, triggered, done;
  logic [5:0]  count;
  logic [15:0] cycles;
  logic [4:0]  rd_idx = '0;
  logic [52:0] rd_data;
  logic [52:0] rd_got;

  int n_checks = 0;
  int n_pass   = 0;

  simple_trace_capture dut (
    .clk(clk), .rst(rst), .restart(restart), .max_cycles(max_cycles),
    .trig_en(trig_en), .trig_pc(trig_pc), .post_cnt(post_cnt),
    .phase_i(phase_i), .pc_i(pc_i), .addr_i(addr_i), .instr_i(instr_i),
    .szcv_i(szcv_i), .jflag_i(jflag_i), .core_rst(core_rst), .running(running),
    .triggered(triggered), .done(done), .count(count), .cycles(cycles),
    .rd_idx(rd_idx), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [52:0] make_rec(input logic [15:0] p);
    return {p, p ^ 16'h5A5A, ~p, p[3:0], p[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Drive one core clock; cap selects whether this clock is the capture phase.
  task automatic applyStimulus(input logic [15:0] p, input logic cap);
    pc_i    = p;
    addr_i  = p ^ 16'h5A5A;
    instr_i = ~p;
    szcv_i  = p[3:0];
    jflag_i = p[0];
    phase_i = cap ? 5'b10000 : 5'b00000;
    tick();
  endtask

  task automatic readEntry(input logic [4:0] idx, output logic [52:0] data);
    phase_i = 5'b00000;
    rd_idx  = idx;
    tick();
    data = rd_data;
  endtask

  task automatic restartRun();
    phase_i = 5'b00000;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    max_cycles = 16'd50;
    repeat (3) tick();
    checkOutput("reset_core_rst", core_rst, 1);
    checkOutput("reset_running", running, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_triggered", triggered, 0);
    checkOutput("reset_count", count, 0);
    checkOutput("reset_cycles", cycles, 0);
    checkOutput("reset_rd_data", rd_data, 0);

    rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checkOutput("hold_core_rst", core_rst, 1);
    end
    tick();
    checkOutput("run_core_rst", core_rst, 0);
    checkOutput("run_running", running, 1);

    // Cycle limit of 50 with a capture every 5th clock.
    for (int k = 1; k <= 50; k++) begin
      applyStimulus(16'(k), (k % 5) == 0);
      if (k == 49) begin
        checkOutput("limit_not_yet", done, 0);
        checkOutput("limit_cycles49", cycles, 49);
      end
    end
    checkOutput("limit_done", done, 1);
    checkOutput("limit_cycles", cycles, 50);
    checkOutput("limit_count", count, 10);
    checkOutput("limit_core_rst", core_rst, 1);
    checkOutput("limit_running", running, 0);
    applyStimulus(16'd99, 1'b1);
    applyStimulus(16'd98, 1'b1);
    checkOutput("done_count_stable", count, 10);
    checkOutput("done_cycles_stable", cycles, 50);
    readEntry(5'd0, rd_got);
    checkOutput("limit_oldest_pc", rd_got[52:37], 5);
    readEntry(5'd9, rd_got);
    checkOutput("limit_newest_rec", rd_got, make_rec(16'd50));
    readEntry(5'd10, rd_got);
    checkOutput("limit_rd_beyond", rd_got, 0);

    // Restart from DONE, then wrap the buffer with 40 captures.
    max_cycles = 16'd0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    checkOutput("rs1_core_rst", core_rst, 1);
    checkOutput("rs1_count", count, 0);
    checkOutput("rs1_cycles", cycles, 0);
    checkOutput("rs1_done", done, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checkOutput("rs1_hold_core_rst", core_rst, 1);
    end
    tick();
    checkOutput("rs1_running", running, 1);
    for (int p = 0; p < 40; p++) applyStimulus(16'(p), 1'b1);
    checkOutput("wrap_count", count, 32);
    checkOutput("wrap_cycles", cycles, 40);
    readEntry(5'd0, rd_got);
    checkOutput("wrap_oldest_pc", rd_got[52:37], 8);
    readEntry(5'd31, rd_got);
    checkOutput("wrap_newest_rec", rd_got, make_rec(16'd39));
    readEntry(5'd16, rd_got);
    checkOutput("wrap_mid_pc", rd_got[52:37], 24);

    // Trigger on pc 7 with three post-trigger captures.
    trig_en  = 1'b1;
    trig_pc  = 16'h0007;
    post_cnt = 6'd3;
    restartRun();
    for (int p = 0; p <= 20; p++) begin
      applyStimulus(16'(p), 1'b1);
      if (p == 6) checkOutput("trig_before", triggered, 0);
      if (p == 7) begin
        checkOutput("trig_fired", triggered, 1);
        checkOutput("trig_post_running", running, 1);
      end
      if (p == 9)  checkOutput("post_not_done", done, 0);
      if (p == 10) checkOutput("post_done", done, 1);
    end
    checkOutput("trig_count", count, 11);
    checkOutput("trig_cycles", cycles, 11);
    readEntry(5'd10, rd_got);
    checkOutput("trig_last_pc", rd_got[52:37], 10);
    readEntry(5'd0, rd_got);
    checkOutput("trig_first_pc", rd_got[52:37], 0);

    // Restart pulse while in POST, with a capture phase present in the same clock.
    trig_pc  = 16'h0002;
    post_cnt = 6'd5;
    restartRun();
    for (int p = 0; p <= 3; p++) applyStimulus(16'(p), 1'b1);
    checkOutput("mid_post_running", running, 1);
    checkOutput("mid_post_trig", triggered, 1);
    checkOutput("mid_post_count", count, 4);
    phase_i = 5'b10000;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    phase_i = 5'b00000;
    checkOutput("rs2_core_rst", core_rst, 1);
    checkOutput("rs2_running", running, 0);
    checkOutput("rs2_triggered", triggered, 0);
    checkOutput("rs2_count", count, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checkOutput("rs2_hold_core_rst", core_rst, 1);
    end
    tick();
    checkOutput("rs2_running_again", running, 1);
    readEntry(5'd0, rd_got);
    checkOutput("rs2_rd_empty", rd_got, 0);

    // Trigger match and cycle limit land in the same clock.
    trig_pc    = 16'h0044;
    post_cnt   = 6'd2;
    max_cycles = 16'd5;
    restartRun();
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(k == 5 ? 16'h0044 : 16'(k), k == 5);
      if (k == 4) checkOutput("both_not_yet", done, 0);
    end
    checkOutput("both_done", done, 1);
    checkOutput("both_triggered", triggered, 1);
    checkOutput("both_count", count, 1);
    checkOutput("both_cycles", cycles, 5);
    readEntry(5'd0, rd_got);
    checkOutput("both_rec", rd_got, make_rec(16'h0044));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
